aes_dec_input_loader: RTL

Upstream loader for the AES-128 decryption datapath.
- Accepts a 32-bit word stream carrying cipher keys and ciphertext blocks over a valid/ready handshake.
- Assembles the words into a 128-bit ciphertext block and an Nk*32-bit key.
- Presents both registered and stable to the decryptor's data and key inputs under an output valid/ready handshake.
- Guarantees the key never changes while a block is being presented.

---
 rtl/aes_dec_input_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/aes_dec_input_loader.sv
// Word-stream loader for the AES-128 decryptor: assembles 32-bit words into a
// ciphertext block and a cipher key, and presents them under a valid/ready handshake.
module aes_dec_input_loader #(
    parameter int Nk = 4,
    parameter int Nb = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_is_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Nb*32-1:0]  data_out,
    output logic [Nk*32-1:0]  key_out,
    output logic              key_loaded
);
    localparam int KW  = Nk * 32;
    localparam int DW  = Nb * 32;
    localparam int KCW = (Nk > 1) ? $clog2(Nk) : 1;
    localparam int DCW = (Nb > 1) ? $clog2(Nb) : 1;

    logic [KCW-1:0] key_cnt_q, key_cnt_d;
    logic [DCW-1:0] dat_cnt_q, dat_cnt_d;
    logic [KW-1:0]  key_shadow_q, key_shadow_d;
    logic [DW-33:0] dat_shadow_q, dat_shadow_d;
    logic           key_pend_q, key_pend_d;
    logic           key_loaded_q, key_loaded_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  data_out_q, data_out_d;
    logic [KW-1:0]  key_out_q, key_out_d;

    logic out_free, key_acc, dat_acc, key_last, dat_last;
    logic key_ready, dat_ready;

    // Key words may not split a half-built block; data waits for a settled key.
    always_comb begin
        out_free  = !out_valid_q || out_ready;
        key_ready = (dat_cnt_q == '0) && !key_pend_q;
        dat_ready = key_loaded_q && (key_cnt_q == '0) && !key_pend_q &&
                    ((dat_cnt_q != DCW'(Nb - 1)) || out_free);
        in_ready  = in_is_key ? key_ready : dat_ready;
        key_acc   = in_valid && in_ready && in_is_key;
        dat_acc   = in_valid && in_ready && !in_is_key;
        key_last  = key_acc && (key_cnt_q == KCW'(Nk - 1));
        dat_last  = dat_acc && (dat_cnt_q == DCW'(Nb - 1));
    end

    always_comb begin
        key_cnt_d    = key_cnt_q;
        dat_cnt_d    = dat_cnt_q;
        key_shadow_d = key_shadow_q;
        dat_shadow_d = dat_shadow_q;
        key_pend_d   = key_pend_q;
        key_loaded_d = key_loaded_q;
        out_valid_d  = out_valid_q;
        data_out_d   = data_out_q;
        key_out_d    = key_out_q;

        if (key_acc) begin
            key_shadow_d = {key_shadow_q[KW-33:0], in_word};
            key_cnt_d    = key_last ? '0 : key_cnt_q + KCW'(1);
        end
        if (key_last) begin
            if (out_free) begin
                key_out_d    = {key_shadow_q[KW-33:0], in_word};
                key_loaded_d = 1'b1;
            end else begin
                key_pend_d   = 1'b1;
            end
        end
        // A deferred key lands on the first edge where no block is being held.
        if (key_pend_q && out_free) begin
            key_out_d    = key_shadow_q;
            key_loaded_d = 1'b1;
            key_pend_d   = 1'b0;
        end

        if (dat_acc) begin
            dat_shadow_d = {dat_shadow_q[DW-65:0], in_word};
            dat_cnt_d    = dat_last ? '0 : dat_cnt_q + DCW'(1);
        end
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        if (dat_last) begin
            out_valid_d = 1'b1;
            data_out_d  = {dat_shadow_q, in_word};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_cnt_q    <= '0;
            dat_cnt_q    <= '0;
            key_shadow_q <= '0;
            dat_shadow_q <= '0;
            key_pend_q   <= 1'b0;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            data_out_q   <= '0;
            key_out_q    <= '0;
        end else begin
            key_cnt_q    <= key_cnt_d;
            dat_cnt_q    <= dat_cnt_d;
            key_shadow_q <= key_shadow_d;
            dat_shadow_q <= dat_shadow_d;
            key_pend_q   <= key_pend_d;
            key_loaded_q <= key_loaded_d;
            out_valid_q  <= out_valid_d;
            data_out_q   <= data_out_d;
            key_out_q    <= key_out_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign data_out   = data_out_q;
    assign key_out    = key_out_q;
    assign key_loaded = key_loaded_q;

endmodule
